fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter WORD_BITWIDTH, default 32, data/address width.
REQ-002 SHALL have parameter RESET_PC, default 32'h00000000, PC value loaded on reset.
REQ-003 SHALL have parameter TIMEOUT, default 16, maximum FETCH cycles awaiting imem_ready (range 2..255).
REQ-004 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port stall  input  1  when high, holds the controller in IDLE instead of starting a fetch.
REQ-007 SHALL have port imem_req  output  1  instruction memory request.
REQ-008 SHALL have port imem_addr  output  WORD_BITWIDTH  fetch address, equal to pc.
REQ-009 SHALL have port imem_ready  input  1  memory data valid this cycle.
REQ-010 SHALL have port imem_rdata  input  WORD_BITWIDTH  fetched instruction word.
REQ-011 SHALL have port instr  output  WORD_BITWIDTH  latched instruction for the datapath.
REQ-012 SHALL have port instr_valid  output  1  one-cycle pulse marking the start of execution.
REQ-013 SHALL have port exec_done  input  1  datapath has completed the current instruction.
REQ-014 SHALL have port branch_pc  input  1  current instruction is a conditional branch.
REQ-015 SHALL have port zero  input  1  ALU zero flag.
REQ-016 SHALL have port imm  input  WORD_BITWIDTH  branch offset in bytes, two's complement.
REQ-017 SHALL have port pc  output  WORD_BITWIDTH  current program counter.
REQ-018 SHALL have port retire_count  output  32  number of retired instructions.
REQ-019 SHALL have port error  output  1  sticky fault flag.
REQ-020 SHALL have port err_cause  output  2  fault cause: 00 none, 01 fetch timeout, 10 misaligned target.

Function
REQ-021 SHALL implement a four-state FSM: IDLE, FETCH, EXEC, ERROR.
REQ-022 SHALL, in IDLE, move to FETCH on the next edge when stall=0, and remain in IDLE when stall=1.
REQ-023 SHALL drive imem_req=1 and imem_addr=pc in every FETCH cycle, and imem_req=0 in every other state.
REQ-024 SHALL count FETCH cycles in a wait counter that clears on FETCH entry.
REQ-025 SHALL, in a FETCH cycle with imem_ready=1, latch instr<=imem_rdata and move to EXEC.
REQ-026 SHALL, in FETCH with imem_ready=0 on wait count TIMEOUT-1, move to ERROR with err_cause=01, so that imem_req is high for exactly TIMEOUT cycles.
REQ-027 SHALL give imem_ready priority over timeout when both occur in the same cycle.
REQ-028 SHALL assert instr_valid only in the first EXEC cycle.
REQ-029 SHALL accept exec_done in any EXEC cycle, including the instr_valid cycle.
REQ-030 SHALL, on exec_done in EXEC, compute next = (branch_pc & zero) ? pc+imm : pc+4, modulo 2^WORD_BITWIDTH, with wrap-around silent.
REQ-031 SHALL, when next[1:0]==00, load pc<=next, increment retire_count (wrapping at 2^32), and go to FETCH if stall=0 or IDLE if stall=1.
REQ-032 SHALL, when next[1:0]!=00, leave pc and retire_count unchanged, set err_cause=10, and go to ERROR.
REQ-033 SHALL keep ERROR until rst, with error=1, imem_req=0 and all other outputs held.
REQ-034 SHALL ignore imem_ready outside FETCH, exec_done outside EXEC, and stall outside IDLE and the exec_done decision.
REQ-035 SHALL make every output registered or decoded from state only, with no combinational input-to-output path.

Reset
REQ-036 SHALL, on a rising clk edge with rst=1, set state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, retire_count=0, error=0, err_cause=00, and clear the wait counter.
REQ-037 SHALL give rst priority over all other inputs and abort any in-progress fetch or execute, including from ERROR.

Verification
REQ-038 SHALL cover: reset, stall=0, imem_ready=1 in 2nd FETCH cycle with rdata=0x00A00093, exec_done 3 cycles later -> instr=0x00A00093, one instr_valid pulse, pc=0x4, retire_count=1.
REQ-039 SHALL cover: pc=0x10, branch_pc=1, zero=1, imm=0xFFFFFFF8 at exec_done -> pc=0x08; repeat with zero=0 -> pc=0x14.
REQ-040 SHALL cover: imem_ready held 0 with TIMEOUT=16 -> imem_req high exactly 16 cycles, then error=1, err_cause=01; imem_ready=1 on the 16th cycle instead -> EXEC, no error.
REQ-041 SHALL cover: branch taken with imm=0x2 -> error=1, err_cause=10, pc unchanged, retire_count unchanged.
REQ-042 SHALL cover: pc=0xFFFFFFFC, non-branch exec_done -> pc=0x00000000, no error.
REQ-043 SHALL cover: stall=1 at exec_done -> IDLE with imem_req=0 until stall drops; rst asserted mid-FETCH -> all reset values on the next edge.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_if
// Instruction-memory request/response bundle between the fetch controller
// and the instruction memory.
//   imem_req   : controller -> memory, request active (one per FETCH cycle)
//   imem_addr  : controller -> memory, fetch address
//   imem_ready : memory -> controller, read data valid this cycle
//   imem_rdata : memory -> controller, fetched instruction word
// Modports: master (controller side), slave (memory side).
// -----------------------------------------------------------------------------
interface fetch_ctrl_if #(
    parameter int unsigned WORD_BITWIDTH = 32
) ();
    logic                     imem_req;
    logic [WORD_BITWIDTH-1:0] imem_addr;
    logic                     imem_ready;
    logic [WORD_BITWIDTH-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Instruction fetch/sequencing controller. Fetches the word at pc, hands it to
// the datapath, waits for completion, then advances pc sequentially or by a
// taken branch offset. Fetch timeouts and misaligned targets trap into a
// sticky ERROR state that only reset leaves.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   stall         : hold in IDLE instead of starting the next fetch
//   imem          : instruction memory bus (fetch_ctrl_if.master)
//   instr         : latched instruction word
//   instr_valid   : one-cycle pulse on the first EXEC cycle
//   exec_done     : datapath finished the current instruction
//   branch_pc     : current instruction is a conditional branch
//   zero          : ALU zero flag (branch taken when branch_pc & zero)
//   imm           : branch byte offset, two's complement
//   pc            : current program counter
//   retire_count  : retired instruction count (wraps)
//   error         : sticky fault flag
//   err_cause     : 00 none, 01 fetch timeout, 10 misaligned target
// -----------------------------------------------------------------------------
module fetch_ctrl #(
    parameter int unsigned              WORD_BITWIDTH = 32,
    parameter logic [WORD_BITWIDTH-1:0] RESET_PC      = '0,
    parameter int unsigned              TIMEOUT       = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    fetch_ctrl_if.master             imem,
    output logic [WORD_BITWIDTH-1:0] instr,
    output logic                     instr_valid,
    input  logic                     exec_done,
    input  logic                     branch_pc,
    input  logic                     zero,
    input  logic [WORD_BITWIDTH-1:0] imm,
    output logic [WORD_BITWIDTH-1:0] pc,
    output logic [31:0]              retire_count,
    output logic                     error,
    output logic [1:0]               err_cause
);

    // Last wait-count value on which a missing imem_ready is a timeout.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StExec,
        StError
    } state_t;

    state_t                   r_state;
    logic [WORD_BITWIDTH-1:0] r_pc;
    logic [WORD_BITWIDTH-1:0] r_instr;
    logic                     r_valid;
    logic                     r_req;
    logic [7:0]               r_wait;
    logic [31:0]              r_retire;
    logic                     r_error;
    logic [1:0]               r_cause;

    logic [WORD_BITWIDTH-1:0] w_next;

    // Candidate next pc; only consumed into registers, never routed to outputs.
    assign w_next = (branch_pc & zero) ? (r_pc + imm) : (r_pc + WORD_BITWIDTH'(4));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_pc     <= RESET_PC;
            r_instr  <= '0;
            r_valid  <= 1'b0;
            r_req    <= 1'b0;
            r_wait   <= '0;
            r_retire <= '0;
            r_error  <= 1'b0;
            r_cause  <= 2'b00;
        end else begin
            r_valid <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (!stall) begin
                        r_state <= StFetch;
                        r_req   <= 1'b1;
                        r_wait  <= '0;
                    end
                end
                StFetch: begin
                    // Data arriving on the last allowed cycle still wins.
                    if (imem.imem_ready) begin
                        r_instr <= imem.imem_rdata;
                        r_valid <= 1'b1;
                        r_req   <= 1'b0;
                        r_state <= StExec;
                    end else if (r_wait == WAIT_LAST) begin
                        r_req   <= 1'b0;
                        r_error <= 1'b1;
                        r_cause <= 2'b01;
                        r_state <= StError;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                StExec: begin
                    if (exec_done) begin
                        if (w_next[1:0] == 2'b00) begin
                            r_pc     <= w_next;
                            r_retire <= r_retire + 32'd1;
                            if (stall) begin
                                r_state <= StIdle;
                            end else begin
                                r_state <= StFetch;
                                r_req   <= 1'b1;
                                r_wait  <= '0;
                            end
                        end else begin
                            r_error <= 1'b1;
                            r_cause <= 2'b10;
                            r_state <= StError;
                        end
                    end
                end
                StError: begin
                    // Sticky until reset.
                end
                default: begin
                    r_state <= StError;
                end
            endcase
        end
    end

    assign imem.imem_req  = r_req;
    assign imem.imem_addr = r_pc;
    assign instr          = r_instr;
    assign instr_valid    = r_valid;
    assign pc             = r_pc;
    assign retire_count   = r_retire;
    assign error          = r_error;
    assign err_cause      = r_cause;

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
// Directed bench for fetch_ctrl. Expected instruction words and pc values are
// queued when stimulus is driven and popped when the DUT produces them.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall;
    logic          exec_done;
    logic          branch_pc;
    logic          zero;
    logic [W-1:0]  imm;
    logic [W-1:0]  instr;
    logic          instr_valid;
    logic [W-1:0]  pc;
    logic [31:0]   retire_count;
    logic          error;
    logic [1:0]    err_cause;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            cnt;
    logic [31:0]   q_instr[$];
    logic [31:0]   q_pc[$];
    logic [31:0]   m_pc;
    logic [31:0]   m_retire;
    logic [31:0]   last_instr;

    always #5 clk = ~clk;

    fetch_ctrl_if #(.WORD_BITWIDTH(W)) bus ();

    fetch_ctrl #(
        .WORD_BITWIDTH(W),
        .RESET_PC     (32'h0000_0000),
        .TIMEOUT      (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .imem        (bus.master),
        .instr       (instr),
        .instr_valid (instr_valid),
        .exec_done   (exec_done),
        .branch_pc   (branch_pc),
        .zero        (zero),
        .imm         (imm),
        .pc          (pc),
        .retire_count(retire_count),
        .error       (error),
        .err_cause   (err_cause)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state();
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_valid", {31'b0, instr_valid}, 32'h0);
        check("rst_req", {31'b0, bus.imem_req}, 32'h0);
        check("rst_retire", retire_count, 32'h0);
        check("rst_error", {31'b0, error}, 32'h0);
        check("rst_cause", {30'b0, err_cause}, 32'h0);
        m_pc       = 32'h0;
        m_retire   = 32'h0;
        last_instr = 32'h0;
        q_instr.delete();
        q_pc.delete();
    endtask

    task automatic do_reset(input logic st);
        rst             = 1'b1;
        stall           = st;
        exec_done       = 1'b0;
        branch_pc       = 1'b0;
        zero            = 1'b0;
        imm             = '0;
        bus.imem_ready  = 1'b0;
        bus.imem_rdata  = '0;
        tick();
        tick();
        rst = 1'b0;
        check_reset_state();
    endtask

    // Entered on the first FETCH cycle; n_wait cycles without ready precede data.
    task automatic fetch(input logic [31:0] rdata, input int n_wait);
        check("fetch_req", {31'b0, bus.imem_req}, 32'h1);
        check("fetch_addr", bus.imem_addr, m_pc);
        repeat (n_wait) begin
            tick();
            check("fetch_wait_req", {31'b0, bus.imem_req}, 32'h1);
        end
        bus.imem_ready = 1'b1;
        bus.imem_rdata = rdata;
        q_instr.push_back(rdata);
        tick();
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'hDEAD_BEEF;
        last_instr     = rdata;
        check("valid_pulse", {31'b0, instr_valid}, 32'h1);
        check("exec_req_low", {31'b0, bus.imem_req}, 32'h0);
        check("instr", instr, q_instr.pop_front());
        check("fetch_no_err", {31'b0, error}, 32'h0);
    endtask

    // Entered on the instr_valid cycle; exec_done arrives n_extra cycles later.
    task automatic exec(input logic br, input logic z, input logic [31:0] off,
                        input int n_extra, input logic st);
        logic [31:0] nxt;
        repeat (n_extra) begin
            tick();
            check("valid_once", {31'b0, instr_valid}, 32'h0);
        end
        nxt       = (br & z) ? (m_pc + off) : (m_pc + 32'd4);
        exec_done = 1'b1;
        branch_pc = br;
        zero      = z;
        imm       = off;
        stall     = st;
        if (nxt[1:0] == 2'b00) q_pc.push_back(nxt);
        else q_pc.push_back(m_pc);
        tick();
        exec_done = 1'b0;
        branch_pc = 1'b0;
        zero      = 1'b0;
        imm       = '0;
        check("exec_pc", pc, q_pc.pop_front());
        if (nxt[1:0] == 2'b00) begin
            m_pc = nxt;
            m_retire++;
            check("exec_retire", retire_count, m_retire);
            check("exec_no_err", {31'b0, error}, 32'h0);
            check("exec_next_req", {31'b0, bus.imem_req}, st ? 32'h0 : 32'h1);
        end else begin
            check("mis_retire", retire_count, m_retire);
            check("mis_error", {31'b0, error}, 32'h1);
            check("mis_cause", {30'b0, err_cause}, 32'h2);
            check("mis_req", {31'b0, bus.imem_req}, 32'h0);
        end
    endtask

    initial begin
        // Reset with stall held: controller must idle.
        do_reset(1'b1);
        repeat (3) begin
            tick();
            check("stall_idle_req", {31'b0, bus.imem_req}, 32'h0);
        end
        stall = 1'b0;
        tick();

        // Basic fetch: ready in 2nd FETCH cycle, exec_done 3 cycles after valid.
        fetch(32'h00A0_0093, 1);
        exec(1'b0, 1'b0, 32'h0, 3, 1'b0);

        // Sequential to 0x10, exec_done in the instr_valid cycle included.
        fetch(32'h0000_0013, 0);
        exec(1'b0, 1'b0, 32'h0, 0, 1'b0);
        fetch(32'h0010_0113, 2);
        exec(1'b0, 1'b0, 32'h0, 1, 1'b0);
        fetch(32'h0020_0193, 0);
        exec(1'b0, 1'b0, 32'h0, 0, 1'b0);
        check("pc_at_10", pc, 32'h10);

        // Taken backward branch 0x10 -> 0x08.
        fetch(32'hFE00_0CE3, 0);
        exec(1'b1, 1'b1, 32'hFFFF_FFF8, 0, 1'b0);
        check("br_taken_pc", pc, 32'h08);
        fetch(32'h0000_0013, 0);
        exec(1'b0, 1'b0, 32'h0, 0, 1'b0);
        fetch(32'h0000_0013, 0);
        exec(1'b0, 1'b0, 32'h0, 0, 1'b0);
        // Not taken: 0x10 -> 0x14.
        fetch(32'hFE00_0CE3, 0);
        exec(1'b1, 1'b0, 32'hFFFF_FFF8, 1, 1'b0);
        check("br_not_taken_pc", pc, 32'h14);
        // zero without branch_pc is sequential.
        fetch(32'h0000_0013, 0);
        exec(1'b0, 1'b1, 32'h40, 0, 1'b0);

        // Misaligned target traps; ERROR ignores all inputs.
        fetch(32'h0000_0263, 0);
        exec(1'b1, 1'b1, 32'h2, 0, 1'b0);
        exec_done      = 1'b1;
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'h1234_5678;
        repeat (3) begin
            tick();
            check("err_hold_req", {31'b0, bus.imem_req}, 32'h0);
            check("err_hold_error", {31'b0, error}, 32'h1);
            check("err_hold_cause", {30'b0, err_cause}, 32'h2);
            check("err_hold_pc", pc, m_pc);
            check("err_hold_instr", instr, last_instr);
            check("err_hold_valid", {31'b0, instr_valid}, 32'h0);
        end

        // Fetch timeout: imem_req high exactly 16 cycles.
        do_reset(1'b0);
        tick();
        cnt = 0;
        for (int i = 0; i < 40 && bus.imem_req === 1'b1; i++) begin
            cnt++;
            tick();
        end
        check("timeout_req_cycles", cnt, 32'd16);
        check("timeout_error", {31'b0, error}, 32'h1);
        check("timeout_cause", {30'b0, err_cause}, 32'h1);

        // Ready on the 16th cycle beats the timeout.
        do_reset(1'b0);
        tick();
        fetch(32'h00A0_0093, 15);
        check("late_ready_cause", {30'b0, err_cause}, 32'h0);
        exec(1'b0, 1'b0, 32'h0, 0, 1'b0);

        // pc wrap-around from 0xFFFFFFFC.
        do_reset(1'b0);
        tick();
        fetch(32'h0000_0013, 0);
        exec(1'b1, 1'b1, 32'hFFFF_FFFC, 0, 1'b0);
        check("pc_top", pc, 32'hFFFF_FFFC);
        fetch(32'h0000_0013, 0);
        exec(1'b0, 1'b0, 32'h0, 0, 1'b0);
        check("pc_wrap", pc, 32'h0);

        // Stall at exec_done parks in IDLE until stall drops.
        fetch(32'h0000_0013, 0);
        exec(1'b0, 1'b0, 32'h0, 1, 1'b1);
        repeat (3) begin
            tick();
            check("stall_park_req", {31'b0, bus.imem_req}, 32'h0);
            check("stall_park_pc", pc, m_pc);
        end
        stall = 1'b0;
        tick();
        check("stall_release_req", {31'b0, bus.imem_req}, 32'h1);
        check("stall_release_addr", bus.imem_addr, m_pc);

        // Reset in the middle of FETCH.
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
